// File: rtl/mem_bist_pkg.sv
// rtl/mem_bist_pkg.sv - shared state type, pattern and saturation helpers for the RAM BIST
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    // Callers truncate to their own data width.
    function automatic logic [31:0] bist_pattern(input logic [31:0] addr,
                                                 input logic [31:0] seed,
                                                 input logic        invert);
        logic [31:0] p;
        p = seed + addr;
        return invert ? ~p : p;
    endfunction

    function automatic logic [31:0] err_sat(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_bist_if.sv
// rtl/mem_bist_if.sv - scratch RAM port (chip-enable/load strobes, registered read data)
interface mem_bist_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ce_n;
    logic              mem_lr_n;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_ce_n,
        output mem_lr_n,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_ce_n,
        input  mem_lr_n,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bist_checker.sv
// rtl/mem_bist_checker.sv - read-data compare, saturating error count and first-fail capture
module mem_bist_checker
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              rd_fire,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [DATA_W-1:0] rdata,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              clean_next
);
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(err_sat(ERR_W));

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] exp_q;
    logic              mismatch;

    assign mismatch   = valid_q && (rdata != exp_q);
    // Lets the sequencer fold the compare landing on its final edge into pass.
    assign clean_next = (err_count == '0) && !mismatch;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            valid_q   <= 1'b0;
            addr_q    <= '0;
            exp_q     <= '0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            valid_q <= rd_fire;
            addr_q  <= rd_addr;
            exp_q   <= rd_exp;
            if (mismatch) begin
                if (err_count != ERR_MAX)
                    err_count <= err_count + ERR_W'(1);
                // Count never returns to zero within a run, so zero marks the first miss.
                if (err_count == '0) begin
                    fail_addr <= addr_q;
                    fail_data <= rdata;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bist_master.sv
// rtl/mem_bist_master.sv - RAM write/read-back BIST sequencer; MEM_BIST_INV_PASS_EN adds an inverted second pass
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    mem_bist_if.master        mem
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bist_state_t       state_q, state_n;
    logic [DATA_W-1:0] seed_q, seed_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              ce_n_q, ce_n_n;
    logic              lr_n_q, lr_n_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              pass_q, pass_n;
    logic              accept;
    logic              inv_cur;
    logic              chk_clean;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] s,
                                              input logic              inv);
        return DATA_W'(bist_pattern(32'(a), 32'(s), inv));
    endfunction

`ifdef MEM_BIST_INV_PASS_EN
    logic inv_q, inv_n;
    assign inv_cur = inv_q;

    always_ff @(posedge clk) begin
        if (!rst_n) inv_q <= 1'b0;
        else        inv_q <= inv_n;
    end
`else
    assign inv_cur = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seed_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ce_n_q  <= 1'b1;
            lr_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            seed_q  <= seed_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            ce_n_q  <= ce_n_n;
            lr_n_q  <= lr_n_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
        end
    end

    // Strobes and address are computed one cycle ahead so the RAM sees registered pins.
    always_comb begin
        state_n = state_q;
        seed_n  = seed_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        ce_n_n  = ce_n_q;
        lr_n_n  = lr_n_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        pass_n  = pass_q;
        accept  = 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
        inv_n   = inv_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ce_n_n = 1'b1;
                lr_n_n = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    seed_n  = seed;
                    pass_n  = 1'b0;
                    busy_n  = 1'b1;
                    addr_n  = '0;
                    lr_n_n  = 1'b0;
                    wdata_n = pat('0, seed, 1'b0);
                    state_n = ST_WRITE;
`ifdef MEM_BIST_INV_PASS_EN
                    inv_n   = 1'b0;
`endif
                end
            end
            ST_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    addr_n  = '0;
                    lr_n_n  = 1'b1;
                    ce_n_n  = 1'b0;
                    state_n = ST_READ;
                end else begin
                    addr_n  = addr_q + ADDR_W'(1);
                    wdata_n = pat(addr_q + ADDR_W'(1), seed_q, inv_cur);
                end
            end
            ST_READ: begin
                if (addr_q == LAST_ADDR) begin
                    addr_n  = '0;
                    ce_n_n  = 1'b1;
                    state_n = ST_DRAIN;
                end else begin
                    addr_n  = addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
`ifdef MEM_BIST_INV_PASS_EN
                if (!inv_q) begin
                    inv_n   = 1'b1;
                    addr_n  = '0;
                    lr_n_n  = 1'b0;
                    wdata_n = pat('0, seed_q, 1'b1);
                    state_n = ST_WRITE;
                end else begin
                    done_n  = 1'b1;
                    pass_n  = chk_clean;
                    state_n = ST_DONE;
                end
`else
                done_n  = 1'b1;
                pass_n  = chk_clean;
                state_n = ST_DONE;
`endif
            end
            ST_DONE: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                ce_n_n  = 1'b1;
                lr_n_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    mem_bist_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ERR_W  (ERR_W)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept),
        .rd_fire    (state_q == ST_READ),
        .rd_addr    (addr_q),
        .rd_exp     (pat(addr_q, seed_q, inv_cur)),
        .rdata      (mem.mem_rdata),
        .err_count  (err_count),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .clean_next (chk_clean)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_ce_n  = ce_n_q;
    assign mem.mem_lr_n  = lr_n_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// tb/tb_mem_bist_master.sv - randomized self-checking bench for mem_bist_master with a faulty-RAM model
module tb_mem_bist_master;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ERR_W  = 8;
`ifdef MEM_BIST_INV_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int LATENCY = (PASSES == 2) ? 4 * DEPTH + 2 : 2 * DEPTH + 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [DATA_W-1:0] seed;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

    mem_bist_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ERR_W  (ERR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .mem       (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with per-address stuck-at-0 / stuck-at-1 bit masks applied on write.
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] sa0 [DEPTH];
    logic [DATA_W-1:0] sa1 [DEPTH];
    int                wr_cnt = 0;
    int                rd_cnt = 0;
    int                done_cnt = 0;
    logic [ADDR_W-1:0] wr_addr_log [$];
    logic [DATA_W-1:0] wr_data_log [$];

    always @(posedge clk) begin
        if (!mif.mem_lr_n) begin
            ram[mif.mem_addr] <= (mif.mem_wdata & ~sa0[mif.mem_addr]) | sa1[mif.mem_addr];
            wr_cnt = wr_cnt + 1;
            wr_addr_log.push_back(mif.mem_addr);
            wr_data_log.push_back(mif.mem_wdata);
        end else if (!mif.mem_ce_n) begin
            mif.mem_rdata <= ram[mif.mem_addr];
            rd_cnt = rd_cnt + 1;
        end
    end

    always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            sa0[a] = '0;
            sa1[a] = '0;
        end
    endtask

    function automatic logic [DATA_W-1:0] expect_word(input logic [DATA_W-1:0] s, input int a, input int p);
        logic [DATA_W-1:0] e;
        e = DATA_W'(int'(s) + a);
        return (p == 1) ? ~e : e;
    endfunction

    task automatic model(input logic [DATA_W-1:0] s, output int errs,
                         output logic [ADDR_W-1:0] fa, output logic [DATA_W-1:0] fd);
        logic [DATA_W-1:0] e, r;
        errs = 0;
        fa   = '0;
        fd   = '0;
        for (int p = 0; p < PASSES; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                e = expect_word(s, a, p);
                r = (e & ~sa0[a]) | sa1[a];
                if (r != e) begin
                    if (errs == 0) begin
                        fa = ADDR_W'(a);
                        fd = r;
                    end
                    errs++;
                end
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_err"}, err_count, 0);
        check_eq({tag, "_faddr"}, fail_addr, 0);
        check_eq({tag, "_fdata"}, fail_data, 0);
        check_eq({tag, "_ce_n"}, mif.mem_ce_n, 1);
        check_eq({tag, "_lr_n"}, mif.mem_lr_n, 1);
        check_eq({tag, "_addr"}, mif.mem_addr, 0);
        check_eq({tag, "_wdata"}, mif.mem_wdata, 0);
    endtask

    task automatic run_bist(input string tag, input logic [DATA_W-1:0] s, input bit poke);
        int n, wb, rb, db, qb, errs, bad;
        bit got;
        logic [ADDR_W-1:0] fa;
        logic [DATA_W-1:0] fd;
        model(s, errs, fa, fd);
        wb = wr_cnt; rb = rd_cnt; db = done_cnt; qb = wr_addr_log.size();
        seed  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_busy_rise"}, busy, 1);
        n = 0;
        got = 0;
        while (n < LATENCY + 20 && !got) begin
            if (poke && n == 9) begin
                start = 1'b1;
                seed  = ~s;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) got = 1;
        end
        check_eq({tag, "_latency"}, n, LATENCY);
        check_eq({tag, "_busy_done"}, busy, 1);
        check_eq({tag, "_pass"}, pass, (errs == 0) ? 1 : 0);
        check_eq({tag, "_err"}, err_count, errs);
        check_eq({tag, "_faddr"}, fail_addr, fa);
        check_eq({tag, "_fdata"}, fail_data, fd);
        if (poke) begin
            start = 1'b1;
            seed  = ~s;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_done_fall"}, done, 0);
        check_eq({tag, "_busy_fall"}, busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_pass_held"}, pass, (errs == 0) ? 1 : 0);
        check_eq({tag, "_done_cnt"}, done_cnt - db, 1);
        check_eq({tag, "_writes"}, wr_cnt - wb, DEPTH * PASSES);
        check_eq({tag, "_reads"}, rd_cnt - rb, DEPTH * PASSES);
        bad = 0;
        for (int k = 0; k < DEPTH * PASSES && qb + k < wr_addr_log.size(); k++) begin
            if (wr_addr_log[qb + k] != ADDR_W'(k % DEPTH) ||
                wr_data_log[qb + k] != expect_word(s, k % DEPTH, k / DEPTH))
                bad++;
        end
        check_eq({tag, "_wr_log_bad"}, bad, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        seed  = '0;
        clear_faults();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_bist("good_s00", 8'h00, 1'b1);

        clear_faults();
        sa0[5][3] = 1'b1;
        run_bist("sa0_a5b3", 8'h08, 1'b0);

        clear_faults();
        sa1[0][0] = 1'b1;
        run_bist("sa1_a0b0", 8'hA5, 1'b0);

        // Abort mid-READ with an error already counted, then rerun cleanly.
        clear_faults();
        sa1[0][7] = 1'b1;
        seed  = 8'h00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check_eq("pre_rst_err", err_count, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset("midrst");
        rst_n = 1'b1;
        clear_faults();
        @(posedge clk); #1;
        run_bist("after_rst_s33", 8'h33, 1'b0);

        for (int i = 0; i < 6; i++) begin
            int nf, fa, fb;
            clear_faults();
            nf = $urandom_range(0, 2);
            for (int j = 0; j < nf; j++) begin
                fa = $urandom_range(0, DEPTH - 1);
                fb = $urandom_range(0, DATA_W - 1);
                if ($urandom_range(0, 1) == 0) sa0[fa][fb] = 1'b1;
                else                           sa1[fa][fb] = 1'b1;
            end
            run_bist($sformatf("rand%0d", i), DATA_W'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
